// File: rtl/usrt_tx_stream.sv
// ---------------------------------------------------------------------------
// usrt_tx_stream
//
// Synchronous-UART transmitter. Words arrive through a one-entry valid/ready
// holding buffer and are serialised onto TXD, one bit per rising edge of the
// externally supplied usrt_clk. Frame = start bit, DATA_W data bits (LSB
// first), optional parity bit, STOP_BITS stop bits. RTS is held high for the
// whole of a back-to-back burst of frames.
//
// Ports
//   clk       in   system clock, all logic on its rising edge
//   rst       in   asynchronous, active-low reset
//   usrt_clk  in   external bit clock, asynchronous to clk (>= 4 clk periods)
//   tx_data   in   word to send (DATA_W bits)
//   tx_valid  in   tx_data valid
//   tx_ready  out  holding buffer empty; a word is accepted this cycle
//   RTS       out  request-to-send, high from burst start to last stop bit end
//   TXD       out  serial data, idle high
//   busy      out  transmitter FSM is not idle
//   tx_done   out  one-cycle pulse at the end of each frame's final stop bit
// ---------------------------------------------------------------------------
module usrt_tx_stream #(
    parameter int DATA_W      = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              usrt_clk,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              RTS,
    output logic              TXD,
    output logic              busy,
    output logic              tx_done
);

    localparam int                 CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic               PAR_INIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // usrt_clk synchroniser and rising-edge detector
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;
    logic                   w_bit_en;

    // holding buffer; r_tx_ready doubles as the "buffer empty" flag
    logic                   r_tx_ready;
    logic [DATA_W-1:0]      r_buf;
    logic                   w_accept;
    logic                   w_load;

    // transmitter
    state_t                 r_state;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      w_shift_next;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_parity;
    logic                   r_stop_cnt;
    logic                   w_last_stop;
    logic                   r_txd;
    logic                   r_rts;
    logic                   r_busy;
    logic                   r_tx_done;

    // -----------------------------------------------------------------------
    // Synchroniser: SYNC_STAGES flops, then one edge flop holding the previous
    // synchronised value. A usrt_clk rise shows up on TXD SYNC_STAGES+1 clk
    // edges later.
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], usrt_clk};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_bit_en = r_sync[SYNC_STAGES-1] & ~r_edge;

    // -----------------------------------------------------------------------
    // Holding buffer. Accept needs the buffer empty and load needs it full, so
    // the two can never coincide.
    // -----------------------------------------------------------------------
    assign w_last_stop = (r_stop_cnt == LAST_STOP);
    assign w_accept    = tx_valid & r_tx_ready;
    assign w_load      = w_bit_en & ~r_tx_ready &
                         ((r_state == S_ARM) || ((r_state == S_STOP) && w_last_stop));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_ready <= 1'b1;
            r_buf      <= '0;
        end else if (w_accept) begin
            r_tx_ready <= 1'b0;
            r_buf      <= tx_data;
        end else if (w_load) begin
            r_tx_ready <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Transmit FSM. TXD always holds the bit for the current bit period, so
    // each transition computes the value of the *next* bit.
    // -----------------------------------------------------------------------
    assign w_shift_next = r_shift >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_txd      <= 1'b1;
            r_rts      <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_tx_ready) begin
                        r_state <= S_ARM;
                        r_rts   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                // RTS is already up; the start bit is aligned to the next
                // usrt_clk rise.
                S_ARM: begin
                    if (w_bit_en) begin
                        r_state  <= S_START;
                        r_txd    <= 1'b0;
                        r_shift  <= r_buf;
                        r_parity <= PAR_INIT;
                    end
                end

                S_START: begin
                    if (w_bit_en) begin
                        r_state   <= S_DATA;
                        r_txd     <= r_shift[0];
                        r_bit_cnt <= '0;
                    end
                end

                // r_shift[0] is the bit currently on the line.
                S_DATA: begin
                    if (w_bit_en) begin
                        r_shift  <= w_shift_next;
                        r_parity <= r_parity ^ r_shift[0];
                        if (r_bit_cnt == LAST_BIT) begin
                            r_stop_cnt <= 1'b0;
                            if (PARITY_EN != 0) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_parity ^ r_shift[0];
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_txd     <= w_shift_next[0];
                        end
                    end
                end

                S_PARITY: begin
                    if (w_bit_en) begin
                        r_state    <= S_STOP;
                        r_txd      <= 1'b1;
                        r_stop_cnt <= 1'b0;
                    end
                end

                // A word already waiting at the end of the last stop bit goes
                // straight into a start bit, keeping RTS up with no idle gap.
                S_STOP: begin
                    if (w_bit_en) begin
                        if (w_last_stop) begin
                            r_tx_done <= 1'b1;
                            if (!r_tx_ready) begin
                                r_state  <= S_START;
                                r_txd    <= 1'b0;
                                r_shift  <= r_buf;
                                r_parity <= PAR_INIT;
                            end else begin
                                r_state <= S_IDLE;
                                r_txd   <= 1'b1;
                                r_rts   <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_rts   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign TXD      = r_txd;
    assign RTS      = r_rts;
    assign busy     = r_busy;
    assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_usrt_tx_stream.sv
// ---------------------------------------------------------------------------
// tb_usrt_tx_stream
//
// Four transmitter configurations run side by side on a shared clk/usrt_clk.
// For each: a stimulus process pushes every accepted word into a queue, and a
// monitor samples TXD once per usrt_clk period, rebuilds each frame and
// compares it with a frame model built from the word (start 0, data LSB
// first, parity by counting ones, stop bits 1).
// ---------------------------------------------------------------------------
module tb_usrt_tx_stream;

    localparam int N_CFG = 4;
    localparam int P_DW [N_CFG] = '{8, 8, 8, 5};
    localparam int P_PE [N_CFG] = '{0, 1, 1, 0};
    localparam int P_PO [N_CFG] = '{0, 0, 1, 0};
    localparam int P_SB [N_CFG] = '{1, 1, 1, 2};
    localparam int P_SS [N_CFG] = '{2, 2, 2, 3};
    localparam logic [31:0] P_FIRST [N_CFG] = '{32'hA5, 32'h07, 32'h07, 32'h13};
    localparam int N_RAND = 16;

    logic clk      = 1'b0;
    logic usrt_clk = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // usrt_clk period = 12 clk periods, edges placed between clk edges
    initial begin
        #2;
        forever #60 usrt_clk = ~usrt_clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < N_CFG; g++) begin : gen_cfg
        localparam int DW = P_DW[g];
        localparam int PE = P_PE[g];
        localparam int PO = P_PO[g];
        localparam int SB = P_SB[g];
        localparam int SS = P_SS[g];
        localparam int FL = 1 + DW + PE + SB;
        localparam logic [63:0] FMASK = (64'd1 << FL) - 64'd1;
        localparam logic [31:0] WMASK = (DW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << DW) - 32'd1);

        logic          rst_l    = 1'b1;
        logic [DW-1:0] tx_data  = '0;
        logic          tx_valid = 1'b0;
        logic          tx_ready;
        logic          rts;
        logic          txd;
        logic          busy;
        logic          tx_done;

        logic [31:0]   exp_q[$];
        int            mon_nbits   = 0;
        int            mon_gap     = 0;
        int            last_gap    = 0;
        int            mon_frames  = 0;
        logic [63:0]   mon_bits    = '1;
        int            done_cnt    = 0;
        int            rts_low_cnt = 0;
        logic          b2b_win     = 1'b0;
        logic          fin         = 1'b0;

        usrt_tx_stream #(
            .DATA_W      (DW),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB),
            .SYNC_STAGES (SS)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_l),
            .usrt_clk (usrt_clk),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .RTS      (rts),
            .TXD      (txd),
            .busy     (busy),
            .tx_done  (tx_done)
        );

        function automatic string nm(input string s);
            return $sformatf("cfg%0d %s", g, s);
        endfunction

        // Reference frame: bit i of the result is the i-th bit on the line.
        function automatic logic [63:0] model_frame(input logic [31:0] w);
            logic [63:0] f;
            int          ones;
            f    = '1;
            f[0] = 1'b0;
            for (int i = 0; i < DW; i++) f[1 + i] = w[i];
            ones = $countones(w & WMASK);
            if (PE != 0) f[1 + DW] = ((ones % 2) == 1) ^ (PO != 0);
            return f;
        endfunction

        // tx_done pulses and RTS drop-outs, sampled mid-cycle
        always @(negedge clk) begin
            if (tx_done) done_cnt++;
            if (b2b_win && !rts) rts_low_cnt++;
        end

        task automatic send(input logic [31:0] w);
            int t;
            @(negedge clk);
            tx_data  = w[DW-1:0];
            tx_valid = 1'b1;
            t = 0;
            while (!tx_ready && t < 4000) begin
                @(negedge clk);
                t++;
            end
            check(nm("accept timeout"), (t < 4000), 1);
            @(posedge clk);
            exp_q.push_back(w & WMASK);
            #1;
            check(nm("tx_ready low while buffer full"), tx_ready, 1'b0);
        endtask

        task automatic idle(input int n);
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = DW'($urandom);
            repeat (n) @(negedge clk);
        endtask

        task automatic drain();
            int t;
            tx_valid = 1'b0;
            t = 0;
            while ((exp_q.size() != 0 || mon_nbits != 0 || busy) && t < 6000) begin
                @(negedge clk);
                t++;
            end
            check(nm("drain timeout"), (t < 6000), 1);
            @(negedge clk);
        endtask

        task automatic check_idle(input string s);
            check(nm({s, " TXD idle"}), txd, 1'b1);
            check(nm({s, " RTS idle"}), rts, 1'b0);
            check(nm({s, " busy idle"}), busy, 1'b0);
            check(nm({s, " tx_ready idle"}), tx_ready, 1'b1);
            check(nm({s, " tx_done count vs frames"}), done_cnt, mon_frames);
        endtask

        // Monitor: one TXD sample per bit period, SS+1 clk edges after the
        // usrt_clk rise (the point where the new bit must already be out).
        initial begin
            logic [31:0] w;
            forever begin
                @(posedge usrt_clk);
                repeat (SS + 1) @(posedge clk);
                #1;
                if (!rst_l) begin
                    mon_nbits = 0;
                    mon_gap   = 0;
                end else if (mon_nbits == 0) begin
                    if (txd == 1'b0) begin
                        last_gap  = mon_gap;
                        mon_gap   = 0;
                        mon_bits  = '1;
                        mon_bits[0] = 1'b0;
                        mon_nbits = 1;
                        check(nm("RTS at start bit"), rts, 1'b1);
                    end else begin
                        mon_gap++;
                    end
                end else begin
                    mon_bits[mon_nbits] = txd;
                    check(nm("RTS during frame"), rts, 1'b1);
                    mon_nbits++;
                    if (mon_nbits == FL) begin
                        mon_nbits = 0;
                        mon_frames++;
                        check(nm("frame had a queued word"), (exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            w = exp_q.pop_front();
                            check(nm("frame bits"), mon_bits & FMASK, model_frame(w) & FMASK);
                        end
                    end
                end
            end
        end

        // Stimulus
        initial begin
            int t;
            int f0;
            int d0;
            int gap;

            #1 rst_l = 1'b0;
            #1;
            check(nm("reset TXD"), txd, 1'b1);
            check(nm("reset RTS"), rts, 1'b0);
            check(nm("reset busy"), busy, 1'b0);
            check(nm("reset tx_done"), tx_done, 1'b0);
            check(nm("reset tx_ready"), tx_ready, 1'b1);
            repeat (3) @(negedge clk);
            rst_l = 1'b1;

            // single directed frame
            send(P_FIRST[g]);
            drain();
            check_idle("single");
            check(nm("single tx_done pulses"), done_cnt, 1);

            // back-to-back: second word arrives while the first is in DATA
            f0 = mon_frames;
            d0 = done_cnt;
            send(32'h01);
            tx_valid = 1'b0;
            t = 0;
            while (mon_nbits == 0 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            b2b_win = 1'b1;
            while (mon_nbits < 3 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            send(32'hFF);
            tx_valid = 1'b0;
            while (mon_frames < f0 + 2 && t < 8000) begin
                @(negedge clk);
                t++;
            end
            b2b_win = 1'b0;
            check(nm("b2b wait timeout"), (t < 8000), 1);
            check(nm("b2b idle bits between frames"), last_gap, 0);
            check(nm("b2b RTS low cycles"), rts_low_cnt, 0);
            drain();
            check(nm("b2b tx_done pulses"), done_cnt - d0, 2);
            check_idle("b2b");

            // backpressure: three words with tx_valid held high throughout
            send($urandom);
            send($urandom);
            send($urandom);
            drain();
            check_idle("backpressure");

            // randomized traffic with random idle gaps
            for (int i = 0; i < N_RAND; i++) begin
                gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200);
                if (gap != 0) idle(gap);
                send($urandom);
            end
            drain();
            check_idle("random");

            // asynchronous reset during the 4th data bit
            send($urandom);
            tx_valid = 1'b0;
            t = 0;
            while (mon_nbits < 4 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            check(nm("reach DATA bit 4 timeout"), (t < 4000), 1);
            #2;
            rst_l = 1'b0;
            #1;
            check(nm("mid-frame reset TXD"), txd, 1'b1);
            check(nm("mid-frame reset RTS"), rts, 1'b0);
            check(nm("mid-frame reset tx_ready"), tx_ready, 1'b1);
            check(nm("mid-frame reset busy"), busy, 1'b0);
            check(nm("mid-frame reset tx_done"), tx_done, 1'b0);
            exp_q.delete();
            repeat (16) @(negedge clk);
            rst_l = 1'b1;
            repeat (48) @(negedge clk);
            check_idle("after reset release");

            send($urandom);
            drain();
            check_idle("post-reset frame");
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(gen_cfg[0].fin && gen_cfg[1].fin && gen_cfg[2].fin && gen_cfg[3].fin)
               && t < 80000) begin
            @(negedge clk);
            t++;
        end
        check("all configurations finished", (t < 80000), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usrt_tx_stream.md
Name: usrt_tx_stream

Overview:
Parametrised successor to the fixed-pattern USRT transmitter. It serialises words from a one-entry valid/ready input buffer onto TXD, one bit per rising edge of the externally supplied usrt_clk. Frame width, parity and stop-bit count are configurable. It drives RTS for the full duration of a back-to-back burst and sits between the system-side data source and the USRT line pins.

Parameters:
DATA_W, 8, data bits per frame (1..32), sent LSB first
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)
SYNC_STAGES, 2, synchroniser depth for usrt_clk (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
usrt_clk  in  1  external bit clock, asynchronous to clk, period >= 4 clk cycles
tx_data  in  DATA_W  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding buffer empty, accepts word this cycle
RTS  out  1  request-to-send, high from burst start to end of last stop bit
TXD  out  1  serial data, idle high
busy  out  1  FSM not in IDLE
tx_done  out  1  one-cycle pulse at end of each frame's final stop bit

Behaviour:
- Reset (rst=0, asynchronous) forces: TXD=1, RTS=0, busy=0, tx_done=0, tx_ready=1, holding buffer empty, FSM=IDLE, synchroniser and edge flop cleared. Reset may occur mid-frame; the line returns to idle immediately, and the partial frame is lost.
- usrt_clk passes through SYNC_STAGES flops plus one edge flop. bit_en is a one-clk pulse when the synchronised value is 1 and the previous value is 0. A usrt_clk rise yields bit_en SYNC_STAGES+1 clk cycles later (with the default, 3).
- Handshake: a word is accepted when tx_valid && tx_ready at a clk edge. tx_ready = holding buffer empty, registered. The buffer empties in the cycle the word moves into the shift register; tx_ready is 1 in the following cycle. tx_data is not sampled while tx_ready=0.
- FSM states: IDLE, ARM, START, DATA, PARITY, STOP.
  - IDLE: if the buffer is full, go to ARM and set RTS=1 on the next clk.
  - ARM: wait for bit_en, then go to START. Set TXD=0, load the shift register from the buffer, clear the buffer, and reset the parity accumulator to PARITY_ODD.
  - START: on bit_en, go to DATA with TXD=shift[0] and bit count=0.
  - DATA: on each bit_en, shift right, XOR the sent bit into parity, and drive TXD with the next bit. After DATA_W bits, go to PARITY (TXD=parity) if PARITY_EN, else go to STOP (TXD=1).
  - PARITY: on bit_en, go to STOP with TXD=1.
  - STOP: hold TXD=1 for STOP_BITS bit_en periods. On the bit_en ending the final stop bit, pulse tx_done.
    - If the buffer is full, go directly to START (TXD=0, load, RTS stays 1) with no idle gap.
    - Otherwise go to IDLE with RTS=0 and TXD=1.
- All outputs are registered. TXD/RTS change on the clk edge where bit_en=1, so each bit is held for exactly one usrt_clk period.
- Simultaneous accept and load in the same cycle is impossible, because load requires the buffer to be full and accept requires it to be empty. An accept in the same cycle as the final stop bit_en is serviced at the next frame boundary.
- Parity covers data bits only. Even parity: data^parity XOR-reduces to 0. Odd parity: it reduces to 1.
- Frame length is 1 + DATA_W + PARITY_EN + STOP_BITS bit periods.

Test Plan:
- Reset: rst low mid-DATA on the 4th bit -> TXD=1, RTS=0, tx_ready=1, busy=0 in the same cycle with no clk. After release, IDLE holds until the next accept.
- Single frame, defaults: tx_data=8'hA5 accepted -> RTS=1; after the next bit_en TXD sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). tx_done pulses once, then RTS=0.
- Parity: PARITY_EN=1, PARITY_ODD=0, tx_data=8'h07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame is 11 bit periods.
- Back-to-back: 8'h01 then 8'hFF presented while the first frame is in DATA -> second start bit follows the stop bit with no idle bit period. RTS stays high across both frames, and tx_done pulses twice.
- Backpressure: tx_valid held high with 3 words -> tx_ready low while the buffer is full. Each word is accepted exactly once, in order, and none are dropped or duplicated.
- Config: DATA_W=5, STOP_BITS=2, SYNC_STAGES=3, tx_data=5'h13 -> TXD 0,1,1,0,0,1,1,1. Bit edges lag usrt_clk rises by 4 clk cycles.
